clock_timekeeper: RTL and testbench
===================================

# clock_timekeeper

Settable 24-hour time-of-day counter with a parametrised clock rate, selectable 12/24-hour display, HH:MM or MM:SS view and a two-field set mode driven by debounced push-button pulses. It sits between the button debouncers and the 4-digit seven-segment scanner. It drives four BCD digit codes plus a blinking colon flag. All logic runs in the single `clk` domain; no derived clocks are used.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency. Must be even and ≥ 4.
- `HALF`, `CLK_HZ/2`: derived local constant; prescaler terminal count + 1.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `btn_mode` in 1: one-cycle debounced pulse; advances the set-mode FSM.
- `btn_inc` in 1: one-cycle debounced pulse; increments the field being set.
- `hour_mode_12` in 1: 1 = 12-hour display, 0 = 24-hour display.
- `show_seconds` in 1: 1 = display MM:SS, 0 = display HH:MM.
- `digit1`..`digit4` out 4 each: BCD digit codes, left to right; 4'hF = blank.
- `ptflag` out 1: colon/blink flag; toggles every `HALF` cycles.
- `pm` out 1: 1 when hours ≥ 12, independent of the display mode.
- `setting` out 2: FSM state code (RUN=0, SET_HOUR=1, SET_MIN=2).

## Operation
- **Counters.** Internal binary counters: `sec` 0–59, `min` 0–59, `hour` 0–23. All three reset to 0.
- **Prescaler.**
  - Counts 0..HALF-1; at HALF-1 it wraps to 0 and toggles `ptflag`.
  - `ptflag` resets to 1.
  - A 0→1 toggle of `ptflag` produces `sec_tick`.
- **RUN, on `sec_tick`.**
  - `sec` increments.
  - 59 → 0 carries into `min`.
  - `min` 59 → 0 carries into `hour`.
  - `hour` 23 → 0 wraps.
  - A full carry is 23:59:59 → 00:00:00 in one edge.
- **FSM.**
  - RUN –`btn_mode`→ SET_HOUR –`btn_mode`→ SET_MIN –`btn_mode`→ RUN.
  - No other transitions.
- **SET_HOUR / SET_MIN.**
  - `sec` is held at 0 and `sec_tick` is ignored.
  - `btn_inc` increments `hour` (23 → 0) or `min` (59 → 0). There is no carry between fields.
- **SET_MIN → RUN.** Clears the prescaler and sets `ptflag` = 1, so the first tick occurs exactly 2·HALF cycles later.
- **Simultaneous events.**
  - `btn_mode` together with `btn_inc`: mode wins and inc is dropped.
  - `btn_inc` in RUN is ignored.
  - `rst` overrides everything and returns to RUN at 00:00:00 from any state.
- **Display mapping, HH:MM.**
  - 24h mode: `digit1` = hour/10, `digit2` = hour%10.
  - 12h mode: displayed hour is 12 for hour 0 or 12, hour−12 for 13–23, and hour otherwise.
  - 12h mode: `digit1` = 4'hF when the tens digit is 0.
- **Display mapping, MM:SS.** `digit1`/`digit2` = min tens/ones; `digit3`/`digit4` = sec tens/ones. `hour_mode_12` has no effect.
- **HH:MM right pair.** `digit3`/`digit4` = min tens/ones.
- **Blink.** In SET_HOUR (or SET_MIN), while `ptflag` = 0, the hour digit pair (or minute digit pair) is forced to 4'hF. This always applies to the HH:MM view; `show_seconds` is ignored while setting.

## Timing
- **Reset values.** `digit1..4` = 0, `ptflag` = 1, `pm` = 0, `setting` = 0.
- **Latency.**
  - Counters update on the edge that samples `sec_tick` or `btn_inc`.
  - `digit*` and `pm` are registered and reflect the new counter value one cycle later.
  - `setting` reflects the new state on the same edge as the transition.
- **Mode inputs.** `hour_mode_12` and `show_seconds` are sampled every cycle and take effect one cycle later.
- **Tick timing.**
  - First `sec_tick` after reset occurs at cycle 2·HALF − 1, counting the first cycle after `rst` deasserts as cycle 0.
  - `sec` = 1 is visible on the digits one cycle after that.
- **Button timing.** Button pulses longer than one cycle count once per asserted cycle; debouncing and edge detection happen upstream.

## Structure
- **Shared package / header.**
  - FSM state encodings: RUN, SET_HOUR, SET_MIN.
  - `BLANK` = 4'hF.
  - Field limits: 59 and 23.
- **Sub-module `half_second_tick`.**
  - Parameter: `HALF`.
  - Ports: `clk`, `rst`, `clr`, `ptflag`, `sec_tick`.
  - Contains the prescaler counter (width `$clog2(HALF)`) and `ptflag`.
- **Top level.** Holds the FSM, the time counters, the 12/24h mapping and the registered digit muxing.

## Test plan
All scenarios use `CLK_HZ` = 8 (`HALF` = 4).
- **Reset and first tick.** Release `rst` and run 8 cycles → `ptflag` 1→0 at cycle 3, 0→1 at cycle 7; digits 0,0,0,0 in HH:MM and 0,0,0,1 in MM:SS one cycle after the tick.
- **Full rollover.** Set the time to 23:59, then run 60 ticks → digits 2,3,5,9 before the wrap, then 0,0,0,0 with `pm` 1→0 on the wrap cycle +1.
- **12h mapping.** Set hour = 0 → digits 1,2,m,m; hour = 13 → F,1,m,m with `pm` = 1; hour = 9 → F,9,m,m.
- **Set mode.**
  - Enter SET_HOUR with 3 `btn_inc` → hour 3.
  - Enter SET_MIN with 61 `btn_inc` → min 1 and hour still 3.
  - Return to RUN → `sec` = 0, and the next tick arrives exactly 8 cycles later.
- **Blink and priority.**
  - In SET_MIN with `ptflag` = 0 → `digit3`/`digit4` = F.
  - Assert `btn_mode` and `btn_inc` in the same cycle in SET_HOUR → state becomes SET_MIN and hour is unchanged.
- **Reset mid-set.** In SET_MIN at 05:17, assert `rst` for 1 cycle → `setting` = 0, digits 0,0,0,0, `ptflag` = 1 on the next cycle.

Source files
------------

// File: rtl/clock_timekeeper_pkg.sv
// Shared types and constants for the clock_timekeeper block.
// Contents: set-mode state encoding, blank digit code, field limits,
// digit payload struct and a small binary-to-BCD helper.
package clock_timekeeper_pkg;

   localparam int unsigned SEC_W  = 6;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned HOUR_W = 5;
   localparam int unsigned DIG_W  = 4;

   localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);
   localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
   localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);
   localparam logic [HOUR_W-1:0] NOON     = HOUR_W'(12);

   localparam logic [DIG_W-1:0] BLANK = 4'hF;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } state_e;

   // Four display digits, left to right.
   typedef struct packed {
      logic [DIG_W-1:0] d1;
      logic [DIG_W-1:0] d2;
      logic [DIG_W-1:0] d3;
      logic [DIG_W-1:0] d4;
   } digits_t;

   // Two-digit BCD of a 0..59 value: {tens, ones}.
   function automatic logic [2*DIG_W-1:0] to_bcd(input logic [5:0] v);
      return {DIG_W'(v / 6'd10), DIG_W'(v % 6'd10)};
   endfunction

endpackage

// File: rtl/clock_timekeeper_if.sv
// Button, display-mode and display-output bundle of clock_timekeeper.
// master: button/mode source side (drives btn_*, hour_mode_12, show_seconds).
// slave : timekeeper side (drives digit1..4, ptflag, pm, setting).
interface clock_timekeeper_if;

   logic       btn_mode;
   logic       btn_inc;
   logic       hour_mode_12;
   logic       show_seconds;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic [3:0] digit4;
   logic       ptflag;
   logic       pm;
   logic [1:0] setting;

   modport master (
      output btn_mode, btn_inc, hour_mode_12, show_seconds,
      input  digit1, digit2, digit3, digit4, ptflag, pm, setting
   );

   modport slave (
      input  btn_mode, btn_inc, hour_mode_12, show_seconds,
      output digit1, digit2, digit3, digit4, ptflag, pm, setting
   );

endinterface

// File: rtl/clock_timekeeper_half_second_tick.sv
// Half-second prescaler: toggles ptflag every HALF cycles and flags the
// 0->1 toggle as sec_tick (combinational, valid in the cycle before it).
// Ports: clk, rst (sync, active-high), clr (restart phase), ptflag, sec_tick.
module half_second_tick #(
   parameter int unsigned HALF = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic ptflag,
   output logic sec_tick
);

   localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] TERM = CW'(HALF - 1);

   logic [CW-1:0] cnt;

   // Prescaler counter and blink flag; clr restarts the phase like reset.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt    <= '0;
         ptflag <= 1'b1;
      end else if (cnt == TERM) begin
         cnt    <= '0;
         ptflag <= ~ptflag;
      end else begin
         cnt    <= cnt + CW'(1);
      end
   end

   // Terminal count while low means the next edge is the rising toggle.
   assign sec_tick = (cnt == TERM) && !ptflag;

endmodule

// File: rtl/clock_timekeeper.sv
// Settable 24-hour time-of-day counter with 12/24h and HH:MM / MM:SS views.
// Ports: clk, rst (sync, active-high), bus (clock_timekeeper_if.slave):
//   in  btn_mode, btn_inc, hour_mode_12, show_seconds
//   out digit1..digit4 (BCD, 4'hF blank), ptflag, pm, setting (state code)
module clock_timekeeper
   import clock_timekeeper_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   clock_timekeeper_if.slave    bus
);

   localparam int unsigned HALF = CLK_HZ / 2;

   state_e              state;
   logic [SEC_W-1:0]    sec;
   logic [MIN_W-1:0]    min;
   logic [HOUR_W-1:0]   hour;
   logic                ptflag;
   logic                sec_tick;
   logic                clr;

   logic [HOUR_W-1:0]   hour_disp_c;
   logic [2*DIG_W-1:0]  hour_bcd_c;
   logic [2*DIG_W-1:0]  min_bcd_c;
   logic [2*DIG_W-1:0]  sec_bcd_c;
   digits_t             digits_c;
   digits_t             digits_q;
   logic                pm_q;

   // Leaving SET_MIN restarts the second so the first tick is a full second away.
   assign clr = (state == SET_MIN) && bus.btn_mode;

   half_second_tick #(.HALF(HALF)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .ptflag   (ptflag),
      .sec_tick (sec_tick)
   );

   // Set-mode FSM and time counters; mode beats inc, ticks only count in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         sec   <= '0;
         min   <= '0;
         hour  <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (bus.btn_mode) begin
                  state <= SET_HOUR;
                  sec   <= '0;
               end else if (sec_tick) begin
                  if (sec == SEC_MAX) begin
                     sec <= '0;
                     if (min == MIN_MAX) begin
                        min  <= '0;
                        hour <= (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
                     end else begin
                        min <= min + MIN_W'(1);
                     end
                  end else begin
                     sec <= sec + SEC_W'(1);
                  end
               end
            end
            SET_HOUR: begin
               sec <= '0;
               if (bus.btn_mode) begin
                  state <= SET_MIN;
               end else if (bus.btn_inc) begin
                  hour <= (hour == HOUR_MAX) ? '0 : hour + HOUR_W'(1);
               end
            end
            SET_MIN: begin
               sec <= '0;
               if (bus.btn_mode) begin
                  state <= RUN;
               end else if (bus.btn_inc) begin
                  min <= (min == MIN_MAX) ? '0 : min + MIN_W'(1);
               end
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   // Display digit selection: 12/24h mapping, view select and set-mode blink.
   always_comb begin
      hour_disp_c = hour;
      digits_c    = '0;
      if (bus.hour_mode_12) begin
         if (hour == '0) begin
            hour_disp_c = NOON;
         end else if (hour > NOON) begin
            hour_disp_c = hour - NOON;
         end
      end
      hour_bcd_c = to_bcd(6'(hour_disp_c));
      min_bcd_c  = to_bcd(min);
      sec_bcd_c  = to_bcd(sec);

      if ((state == RUN) && bus.show_seconds) begin
         digits_c = {min_bcd_c, sec_bcd_c};
      end else begin
         digits_c = {hour_bcd_c, min_bcd_c};
         if (bus.hour_mode_12 && (hour_bcd_c[7:4] == 4'd0)) begin
            digits_c.d1 = BLANK;
         end
         if (!ptflag && (state == SET_HOUR)) begin
            digits_c.d1 = BLANK;
            digits_c.d2 = BLANK;
         end
         if (!ptflag && (state == SET_MIN)) begin
            digits_c.d3 = BLANK;
            digits_c.d4 = BLANK;
         end
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q <= '0;
         pm_q     <= 1'b0;
      end else begin
         digits_q <= digits_c;
         pm_q     <= (hour >= NOON);
      end
   end

   assign bus.digit1  = digits_q.d1;
   assign bus.digit2  = digits_q.d2;
   assign bus.digit3  = digits_q.d3;
   assign bus.digit4  = digits_q.d4;
   assign bus.pm      = pm_q;
   assign bus.ptflag  = ptflag;
   assign bus.setting = state;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper at CLK_HZ = 8 (HALF = 4).
// The reference keeps time as seconds-of-day and the prescaler phase as
// cycles since the last restart; every cycle all outputs are compared.
module tb_clock_timekeeper;

   localparam int unsigned CLK_HZ = 8;
   localparam int          HALF   = CLK_HZ / 2;
   localparam int          DAY    = 86400;

   logic clk = 1'b0;
   logic rst;

   clock_timekeeper_if bus ();

   clock_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state.
   int          m_tod;    // seconds since midnight
   int          m_st;     // 0 run, 1 set hour, 2 set minute
   int          m_since;  // cycles since reset / restart of the second
   bit          h12;
   bit          ss;
   logic [15:0] exp_dig;
   bit          exp_pm;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   function automatic bit flag_of(input int since);
      return ((since / HALF) % 2) == 0;
   endfunction

   function automatic logic [15:0] disp(input int tod, input int st, input bit flag,
                                        input bit m12, input bit mss);
      int h, m, s, hd;
      logic [3:0] a, b, c, d;
      h = tod / 3600;
      m = (tod / 60) % 60;
      s = tod % 60;
      if (st == 0 && mss) return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
      hd = m12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
      a = (m12 && hd < 10) ? 4'hF : 4'(hd / 10);
      b = 4'(hd % 10);
      c = 4'(m / 10);
      d = 4'(m % 10);
      if (!flag && st == 1) begin a = 4'hF; b = 4'hF; end
      if (!flag && st == 2) begin c = 4'hF; d = 4'hF; end
      return {a, b, c, d};
   endfunction

   // One clock: drive inputs, advance the reference, compare after the edge.
   task automatic step(input bit r, input bit md, input bit inc);
      bit tick;
      bit flag;
      rst              = r;
      bus.btn_mode     = md;
      bus.btn_inc      = inc;
      bus.hour_mode_12 = h12;
      bus.show_seconds = ss;
      if (r) begin
         exp_dig = 16'h0000;
         exp_pm  = 1'b0;
         m_tod   = 0;
         m_st    = 0;
         m_since = 0;
      end else begin
         flag    = flag_of(m_since);
         tick    = (m_since % (2 * HALF)) == (2 * HALF - 1);
         exp_dig = disp(m_tod, m_st, flag, h12, ss);
         exp_pm  = (m_tod / 3600) >= 12;
         m_since++;
         case (m_st)
            0: if (md) begin
                  m_st  = 1;
                  m_tod = m_tod - m_tod % 60;
               end else if (tick) begin
                  m_tod = (m_tod + 1) % DAY;
               end
            1: if (md) m_st = 2;
               else if (inc) m_tod = ((m_tod / 3600 + 1) % 24) * 3600 + m_tod % 3600;
            2: if (md) begin
                  m_st    = 0;
                  m_since = 0;
               end else if (inc) begin
                  m_tod = (m_tod / 3600) * 3600 + (((m_tod / 60) % 60 + 1) % 60) * 60 + m_tod % 60;
               end
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      check("digits", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, exp_dig);
      check("ptflag", 16'(bus.ptflag), 16'(flag_of(m_since)));
      check("pm", 16'(bus.pm), 16'(exp_pm));
      check("setting", 16'(bus.setting), 16'(m_st));
   endtask

   // From RUN: walk through both set states to reach h:mi, back in RUN.
   task automatic set_time(input int h, input int mi);
      int nh, nm;
      step(0, 1, 0);
      nh = (h - m_tod / 3600 + 24) % 24;
      repeat (nh) step(0, 0, 1);
      step(0, 1, 0);
      nm = (mi - (m_tod / 60) % 60 + 60) % 60;
      repeat (nm) step(0, 0, 1);
      step(0, 1, 0);
   endtask

   initial begin
      h12              = 1'b0;
      ss               = 1'b0;
      rst              = 1'b1;
      bus.btn_mode     = 1'b0;
      bus.btn_inc      = 1'b0;
      bus.hour_mode_12 = 1'b0;
      bus.show_seconds = 1'b0;

      // Reset state.
      step(1, 0, 0);
      step(1, 0, 0);
      check("rst_digits", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h0000);
      check("rst_ptflag", 16'(bus.ptflag), 16'h0001);

      // First tick: sec = 1 visible in MM:SS at cycle 9.
      ss = 1'b1;
      repeat (10) step(0, 0, 0);
      check("first_tick_mmss", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h0001);
      ss = 1'b0;
      step(0, 0, 0);
      check("first_tick_hhmm", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h0000);

      // Full rollover from 23:59:00.
      set_time(23, 59);
      step(0, 0, 0);
      check("pre_wrap", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h2359);
      check("pre_wrap_pm", 16'(bus.pm), 16'h0001);
      repeat (60 * 2 * HALF) step(0, 0, 0);
      check("post_wrap", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h0000);
      check("post_wrap_pm", 16'(bus.pm), 16'h0000);

      // 12-hour mapping.
      h12 = 1'b1;
      set_time(0, 7);
      step(0, 0, 0);
      check("h12_midnight", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h1207);
      set_time(13, 7);
      step(0, 0, 0);
      check("h12_13", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'hF107);
      check("h12_13_pm", 16'(bus.pm), 16'h0001);
      set_time(9, 7);
      step(0, 0, 0);
      check("h12_9", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'hF907);
      h12 = 1'b0;

      // Set mode from 00:00: 3 hour incs, 61 minute incs.
      step(1, 0, 0);
      step(0, 1, 0);
      repeat (3) step(0, 0, 1);
      step(0, 1, 0);
      repeat (61) step(0, 0, 1);
      step(0, 1, 0);
      step(0, 0, 0);
      check("set_result", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h0301);
      ss = 1'b1;
      repeat (7) step(0, 0, 0);
      check("tick_not_yet", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h0100);
      step(0, 0, 0);
      check("tick_after_set", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h0101);

      // Blink of the minute pair in SET_MIN.
      step(0, 1, 0);
      step(0, 1, 0);
      for (int k = 0; k < 2 * HALF && flag_of(m_since); k++) step(0, 0, 0);
      step(0, 0, 0);
      check("blink_min", 16'({bus.digit3, bus.digit4}), 16'h00FF);

      // Mode and inc together in SET_HOUR: mode wins.
      ss = 1'b0;
      step(0, 1, 0);
      step(0, 1, 0);
      step(0, 1, 1);
      check("prio_state", 16'(bus.setting), 16'h0002);
      step(0, 1, 0);
      step(0, 0, 0);
      check("prio_hour", 16'({bus.digit1, bus.digit2}), 16'h0003);

      // Reset while setting at 05:17.
      set_time(5, 17);
      step(0, 1, 0);
      step(0, 1, 0);
      step(1, 0, 0);
      check("midset_rst_state", 16'(bus.setting), 16'h0000);
      check("midset_rst_digits", {bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 16'h0000);
      check("midset_rst_ptflag", 16'(bus.ptflag), 16'h0001);

      // Randomized traffic against the reference.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(49) == 0) h12 = ~h12;
         if ($urandom_range(49) == 0) ss = ~ss;
         step($urandom_range(599) == 0, $urandom_range(39) == 0, $urandom_range(2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
